// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store alignment unit.
//   - MemOp encodings (size in bits [1:0], unsigned flag in bit [2])
//   - FSM state enum
//   - Error-cause codes, which are kept internally so the single out_err
//     flag can be traced back to its reason
//   - Helpers for legality, alignment and byte-lane masks
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_CONFLICT = 3'd1;  // load and store both requested
    localparam logic [2:0] ERR_MEMOP    = 3'd2;  // unknown code, or unsigned store
    localparam logic [2:0] ERR_MISALIGN = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

    // A code is legal if it is a known size; unsigned codes are load-only.
    function automatic logic memop_legal(input logic [2:0] op, input logic is_store);
        logic ok;
        case (op)
            MEMOP_B, MEMOP_H, MEMOP_W: ok = 1'b1;
            MEMOP_BU, MEMOP_HU:        ok = ~is_store;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Natural alignment check for the access size.
    function automatic logic memop_aligned(input logic [2:0] op, input logic [1:0] off);
        logic ok;
        case (op)
            MEMOP_W:            ok = (off == 2'b00);
            MEMOP_H, MEMOP_HU:  ok = (off[0] == 1'b0);
            MEMOP_B, MEMOP_BU:  ok = 1'b1;
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane enables for an aligned access.
    function automatic logic [3:0] memop_mask(input logic [2:0] op, input logic [1:0] off);
        logic [3:0] m;
        case (op)
            MEMOP_B, MEMOP_BU:  m = 4'b0001 << off;
            MEMOP_H, MEMOP_HU:  m = 4'b0011 << off;
            MEMOP_W:            m = 4'b1111;
            default:            m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align_if.sv
// -----------------------------------------------------------------------------
// lsu_align_if
// Bundles the three handshakes of the alignment unit:
//   execute side : in_valid/in_ready, in_addr, in_wdata, in_MemOp, in_WrEn, in_RdEn
//   memory side  : mem_req_valid/mem_req_ready, mem_addr, mem_wen, mem_wdata,
//                  mem_wmask, mem_rsp_valid, mem_rdata
//   writeback    : out_valid/out_ready, out_rdata, out_err
// slave  : the alignment unit itself
// master : the environment (execute stage + memory + writeback)
// -----------------------------------------------------------------------------
interface lsu_align_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic [2:0]    in_MemOp;
    logic          in_WrEn;
    logic          in_RdEn;

    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rdata;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_rdata;
    logic          out_err;

    modport slave (
        input  in_valid, in_addr, in_wdata, in_MemOp, in_WrEn, in_RdEn,
        output in_ready,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output out_valid, out_rdata, out_err,
        input  out_ready
    );

    modport master (
        output in_valid, in_addr, in_wdata, in_MemOp, in_WrEn, in_RdEn,
        input  in_ready,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  out_valid, out_rdata, out_err,
        output out_ready
    );
endinterface

// File: rtl/lsu_extend.sv
// -----------------------------------------------------------------------------
// lsu_extend
// Combinational load-data extraction: shifts the addressed lane down to bit 0
// and sign- or zero-extends according to MemOp.
//   i_rdata  : full aligned word from memory
//   i_off    : byte offset within the word
//   i_memop  : access size/sign code
//   o_result : extended value (0 for an unknown code)
// -----------------------------------------------------------------------------
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_rdata,
    input  logic [1:0]    i_off,
    input  logic [2:0]    i_memop,
    output logic [DW-1:0] o_result
);

    logic [DW-1:0] w_shifted;

    // Lane shift followed by size/sign selection.
    always_comb begin
        w_shifted = i_rdata >> {i_off, 3'b000};
        o_result  = '0;
        case (i_memop)
            MEMOP_B:  o_result = {{(DW-8){w_shifted[7]}},   w_shifted[7:0]};
            MEMOP_H:  o_result = {{(DW-16){w_shifted[15]}}, w_shifted[15:0]};
            MEMOP_W:  o_result = w_shifted;
            MEMOP_BU: o_result = {{(DW-8){1'b0}},           w_shifted[7:0]};
            MEMOP_HU: o_result = {{(DW-16){1'b0}},          w_shifted[15:0]};
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Load/store alignment unit between execute and the data-memory port.
// One access is taken per in_valid/in_ready handshake. Legal, aligned accesses
// produce a word-aligned memory request with lane enables and lane-shifted
// store data; the unit then waits for the response and returns extended load
// data. Conflicting, illegal or misaligned accesses never reach memory and
// complete with out_err one cycle after acceptance.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : lsu_align_if.slave (execute, memory and writeback handshakes)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    lsu_align_if.slave  bus
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

    lsu_state_e    r_state,         w_state_nxt;
    logic          r_in_ready,      w_in_ready_nxt;
    logic          r_mem_req_valid, w_mem_req_valid_nxt;
    logic [AW-1:0] r_mem_addr,      w_mem_addr_nxt;
    logic          r_mem_wen,       w_mem_wen_nxt;
    logic [DW-1:0] r_mem_wdata,     w_mem_wdata_nxt;
    logic [3:0]    r_mem_wmask,     w_mem_wmask_nxt;
    logic          r_out_valid,     w_out_valid_nxt;
    logic [DW-1:0] r_out_rdata,     w_out_rdata_nxt;
    logic          r_out_err,       w_out_err_nxt;
    logic [2:0]    r_err_cause,     w_err_cause_nxt;
    logic [1:0]    r_off,           w_off_nxt;
    logic [2:0]    r_memop,         w_memop_nxt;
    logic          r_is_load,       w_is_load_nxt;
    logic [CW-1:0] r_cnt,           w_cnt_nxt;

    logic [1:0]    w_off;
    logic          w_noop;
    logic          w_conflict;
    logic          w_legal;
    logic          w_aligned;
    logic [3:0]    w_mask;
    logic [DW-1:0] w_wdata_sh;
    logic [DW-1:0] w_ext;
    logic [DW-1:0] w_rsp_result;

    // Request decode, evaluated on the live execute-stage inputs.
    assign w_off      = bus.in_addr[1:0];
    assign w_noop     = ~bus.in_WrEn & ~bus.in_RdEn;
    assign w_conflict = bus.in_WrEn & bus.in_RdEn;
    assign w_legal    = memop_legal(bus.in_MemOp, bus.in_WrEn);
    assign w_aligned  = memop_aligned(bus.in_MemOp, w_off);
    assign w_mask     = memop_mask(bus.in_MemOp, w_off);
    assign w_wdata_sh = bus.in_wdata << {w_off, 3'b000};

    // Extraction uses the latched offset/MemOp so the execute inputs may move.
    lsu_extend #(.DW(DW)) u_extend (
        .i_rdata  (bus.mem_rdata),
        .i_off    (r_off),
        .i_memop  (r_memop),
        .o_result (w_ext)
    );

    // Stores write back zero; loads write back the extended lane.
    assign w_rsp_result = r_is_load ? w_ext : '0;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt         = r_state;
        w_mem_req_valid_nxt = r_mem_req_valid;
        w_mem_addr_nxt      = r_mem_addr;
        w_mem_wen_nxt       = r_mem_wen;
        w_mem_wdata_nxt     = r_mem_wdata;
        w_mem_wmask_nxt     = r_mem_wmask;
        w_out_rdata_nxt     = r_out_rdata;
        w_err_cause_nxt     = r_err_cause;
        w_off_nxt           = r_off;
        w_memop_nxt         = r_memop;
        w_is_load_nxt       = r_is_load;
        w_cnt_nxt           = r_cnt;

        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_out_rdata_nxt = '0;
                    if (w_noop) begin
                        w_state_nxt     = DONE;
                        w_err_cause_nxt = ERR_NONE;
                    end else if (w_conflict) begin
                        w_state_nxt     = DONE;
                        w_err_cause_nxt = ERR_CONFLICT;
                    end else if (!w_legal) begin
                        w_state_nxt     = DONE;
                        w_err_cause_nxt = ERR_MEMOP;
                    end else if (!w_aligned) begin
                        w_state_nxt     = DONE;
                        w_err_cause_nxt = ERR_MISALIGN;
                    end else begin
                        w_state_nxt         = REQ;
                        w_err_cause_nxt     = ERR_NONE;
                        w_mem_req_valid_nxt = 1'b1;
                        w_mem_addr_nxt      = {bus.in_addr[AW-1:2], 2'b00};
                        w_mem_wen_nxt       = bus.in_WrEn;
                        // Loads carry no lane enables or write data.
                        w_mem_wmask_nxt     = bus.in_WrEn ? w_mask : 4'b0000;
                        w_mem_wdata_nxt     = bus.in_WrEn ? w_wdata_sh : '0;
                        w_off_nxt           = w_off;
                        w_memop_nxt         = bus.in_MemOp;
                        w_is_load_nxt       = bus.in_RdEn;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            REQ: begin
                if (bus.mem_req_ready) begin
                    w_mem_req_valid_nxt = 1'b0;
                    w_cnt_nxt           = '0;
                    // Zero-wait memory answers in the handshake cycle itself.
                    if (bus.mem_rsp_valid) begin
                        w_state_nxt     = DONE;
                        w_out_rdata_nxt = w_rsp_result;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end else begin
                    w_state_nxt = REQ;
                end
            end

            WAIT: begin
                // A response arriving on the limit cycle still wins.
                if (bus.mem_rsp_valid) begin
                    w_state_nxt     = DONE;
                    w_out_rdata_nxt = w_rsp_result;
                end else if (r_cnt == TO_LIMIT) begin
                    w_state_nxt     = DONE;
                    w_out_rdata_nxt = '0;
                    w_err_cause_nxt = ERR_TIMEOUT;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt     = IDLE;
                    w_out_rdata_nxt = '0;
                    w_err_cause_nxt = ERR_NONE;
                end else begin
                    w_state_nxt = DONE;
                end
            end

            default: begin
                w_state_nxt         = IDLE;
                w_mem_req_valid_nxt = 1'b0;
                w_out_rdata_nxt     = '0;
                w_err_cause_nxt     = ERR_NONE;
            end
        endcase

        w_in_ready_nxt  = (w_state_nxt == IDLE);
        w_out_valid_nxt = (w_state_nxt == DONE);
        w_out_err_nxt   = (w_err_cause_nxt != ERR_NONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_in_ready      <= 1'b1;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wen       <= 1'b0;
            r_mem_wdata     <= '0;
            r_mem_wmask     <= 4'b0000;
            r_out_valid     <= 1'b0;
            r_out_rdata     <= '0;
            r_out_err       <= 1'b0;
            r_err_cause     <= ERR_NONE;
            r_off           <= 2'b00;
            r_memop         <= 3'b000;
            r_is_load       <= 1'b0;
            r_cnt           <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_in_ready      <= w_in_ready_nxt;
            r_mem_req_valid <= w_mem_req_valid_nxt;
            r_mem_addr      <= w_mem_addr_nxt;
            r_mem_wen       <= w_mem_wen_nxt;
            r_mem_wdata     <= w_mem_wdata_nxt;
            r_mem_wmask     <= w_mem_wmask_nxt;
            r_out_valid     <= w_out_valid_nxt;
            r_out_rdata     <= w_out_rdata_nxt;
            r_out_err       <= w_out_err_nxt;
            r_err_cause     <= w_err_cause_nxt;
            r_off           <= w_off_nxt;
            r_memop         <= w_memop_nxt;
            r_is_load       <= w_is_load_nxt;
            r_cnt           <= w_cnt_nxt;
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wen       = r_mem_wen;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.mem_wmask     = r_mem_wmask;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_rdata     = r_out_rdata;
    assign bus.out_err       = r_out_err;

endmodule

// File: tb/tb_lsu_align.sv
// -----------------------------------------------------------------------------
// tb_lsu_align
// Self-checking bench for lsu_align: directed cases from the access rules plus
// randomized accesses, each compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_lsu_align;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lsu_align_if #(.AW(32), .DW(32)) bus ();

    lsu_align #(.AW(32), .DW(32), .TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what a single access should do, from the access rules.
    function automatic void ref_model(
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [2:0]  op,
        input  logic        wr,
        input  logic        rd,
        input  logic [31:0] rdata,
        output logic        go,
        output logic        err,
        output logic [31:0] e_addr,
        output logic [31:0] e_wdata,
        output logic [3:0]  e_mask,
        output logic [31:0] e_res
    );
        int          off;
        int          nbytes;
        logic        legal;
        logic [63:0] lane;
        logic [63:0] fmask;
        off    = int'(addr[1:0]);
        nbytes = 1 << op[1:0];
        legal  = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) ||
                 (!wr && ((op == 3'd4) || (op == 3'd5)));
        go      = 1'b0;
        err     = 1'b0;
        e_addr  = addr - 32'(off);
        e_wdata = 32'd0;
        e_mask  = 4'd0;
        e_res   = 32'd0;
        if (wr || rd) begin
            if ((wr && rd) || !legal || ((off % nbytes) != 0)) begin
                err = 1'b1;
            end else begin
                go = 1'b1;
                if (wr) begin
                    e_mask  = 4'(((1 << nbytes) - 1) << off);
                    e_wdata = wdata << (8 * off);
                end else begin
                    lane  = {32'd0, rdata} >> (8 * off);
                    fmask = (64'd1 << (8 * nbytes)) - 64'd1;
                    lane  = lane & fmask;
                    if (!op[2] && lane[8 * nbytes - 1]) lane = lane | ~fmask;
                    e_res = lane[31:0];
                end
            end
        end
    endfunction

    // One complete access: accept, memory phase (if any), writeback.
    task automatic do_access(
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [2:0]  op,
        input  logic        wr,
        input  logic        rd,
        input  logic [31:0] rdata,
        input  int          req_dly,
        input  int          rsp_dly,
        input  int          out_dly,
        output logic [31:0] o_rdata,
        output logic        o_err
    );
        logic        go, e_err;
        logic [31:0] e_addr, e_wdata, e_res;
        logic [3:0]  e_mask;
        int          w;
        ref_model(addr, wdata, op, wr, rd, rdata, go, e_err, e_addr, e_wdata, e_mask, e_res);

        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        check("in_ready_idle", bus.in_ready, 32'd1);

        bus.in_valid = 1'b1;
        bus.in_addr  = addr;
        bus.in_wdata = wdata;
        bus.in_MemOp = op;
        bus.in_WrEn  = wr;
        bus.in_RdEn  = rd;
        step();
        bus.in_valid = 1'b0;
        bus.in_addr  = $urandom;
        bus.in_wdata = $urandom;
        bus.in_MemOp = 3'($urandom);
        bus.in_WrEn  = 1'($urandom);
        bus.in_RdEn  = 1'($urandom);

        if (!go) begin
            check("fast_valid", bus.out_valid, 32'd1);
            check("fast_noreq", bus.mem_req_valid, 32'd0);
            check("fast_err", bus.out_err, 32'(e_err));
            if (!e_err) check("noop_rdata", bus.out_rdata, 32'd0);
        end else begin
            check("req_valid", bus.mem_req_valid, 32'd1);
            check("req_addr", bus.mem_addr, e_addr);
            check("req_wen", bus.mem_wen, 32'(wr));
            check("req_mask", bus.mem_wmask, 32'(e_mask));
            if (wr) check("req_wdata", bus.mem_wdata, e_wdata);
            for (int i = 0; i < req_dly; i++) begin
                bus.mem_rsp_valid = 1'($urandom);
                bus.mem_rdata     = $urandom;
                step();
                check("stall_valid", bus.mem_req_valid, 32'd1);
                check("stall_addr", bus.mem_addr, e_addr);
                check("stall_mask", bus.mem_wmask, 32'(e_mask));
                check("stall_outv", bus.out_valid, 32'd0);
            end
            bus.mem_req_ready = 1'b1;
            bus.mem_rsp_valid = (rsp_dly == 0);
            bus.mem_rdata     = (rsp_dly == 0) ? rdata : $urandom;
            step();
            bus.mem_req_ready = 1'b0;
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rdata     = $urandom;
            if (rsp_dly > 0) begin
                check("req_dropped", bus.mem_req_valid, 32'd0);
                for (int i = 1; i < rsp_dly; i++) begin
                    step();
                    bus.mem_rdata = $urandom;
                end
                check("wait_outv", bus.out_valid, 32'd0);
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rdata     = rdata;
                step();
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rdata     = $urandom;
            end
            check("done_valid", bus.out_valid, 32'd1);
            check("done_err", bus.out_err, 32'd0);
            check("done_rdata", bus.out_rdata, e_res);
        end

        o_rdata = bus.out_rdata;
        o_err   = bus.out_err;

        for (int i = 0; i < out_dly; i++) begin
            step();
            check("hold_valid", bus.out_valid, 32'd1);
            check("hold_err", bus.out_err, 32'(e_err));
            if (!e_err) check("hold_rdata", bus.out_rdata, e_res);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("drop_valid", bus.out_valid, 32'd0);
        check("back_ready", bus.in_ready, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        logic [2:0]  op;
        logic        wr, rd;
        int          k, n;

        bus.in_valid      = 1'b0;
        bus.in_addr       = 32'd0;
        bus.in_wdata      = 32'd0;
        bus.in_MemOp      = 3'd0;
        bus.in_WrEn       = 1'b0;
        bus.in_RdEn       = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 32'd0;
        bus.out_ready     = 1'b0;
        rst = 1'b1;
        #12;
        check("rst_in_ready", bus.in_ready, 32'd1);
        check("rst_req_valid", bus.mem_req_valid, 32'd0);
        check("rst_wen", bus.mem_wen, 32'd0);
        check("rst_wmask", bus.mem_wmask, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_out_rdata", bus.out_rdata, 32'd0);
        check("rst_out_err", bus.out_err, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Directed accesses with literal expectations.
        do_access(32'h8000_0003, 32'h0, 3'b000, 1'b0, 1'b1, 32'h80FF_1234, 0, 0, 0, r, e);
        check("lb_val", r, 32'hFFFF_FF80);
        do_access(32'h8000_0002, 32'h0, 3'b101, 1'b0, 1'b1, 32'hBEEF_0000, 0, 1, 0, r, e);
        check("lhu_val", r, 32'h0000_BEEF);
        do_access(32'h8000_0002, 32'h0, 3'b001, 1'b0, 1'b1, 32'hBEEF_0000, 1, 0, 1, r, e);
        check("lh_val", r, 32'hFFFF_BEEF);
        do_access(32'h8000_0001, 32'h0000_00AB, 3'b000, 1'b1, 1'b0, 32'h0, 0, 0, 0, r, e);
        check("sb_val", r, 32'h0);
        do_access(32'h8000_0002, 32'h1234_5678, 3'b010, 1'b1, 1'b0, 32'h0, 0, 0, 0, r, e);
        check("sw_mis_err", 32'(e), 32'd1);
        do_access(32'h8000_0000, 32'h0, 3'b111, 1'b0, 1'b1, 32'h0, 0, 0, 0, r, e);
        check("lw_ill_err", 32'(e), 32'd1);
        do_access(32'h8000_0000, 32'h0, 3'b100, 1'b1, 1'b0, 32'h0, 0, 0, 0, r, e);
        check("sbu_ill_err", 32'(e), 32'd1);
        do_access(32'h8000_0004, 32'h0, 3'b010, 1'b1, 1'b1, 32'h0, 0, 0, 0, r, e);
        check("both_err", 32'(e), 32'd1);
        // Stalled request, late response, slow writeback.
        do_access(32'h8000_0008, 32'h0, 3'b010, 1'b0, 1'b1, 32'hCAFE_F00D, 5, 3, 4, r, e);
        check("lw_slow_val", r, 32'hCAFE_F00D);

        // Randomized accesses against the model.
        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(0, 9);
            case (k)
                0: op = 3'b000;
                1: op = 3'b001;
                2: op = 3'b010;
                3: op = 3'b100;
                4: op = 3'b101;
                default: op = 3'($urandom);
            endcase
            k = $urandom_range(0, 9);
            wr = (k >= 4 && k <= 7) || (k == 9);
            rd = (k <= 3) || (k == 9);
            do_access($urandom, $urandom, op, wr, rd, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r, e);
        end

        // Reset while waiting for memory; the late response must be dropped.
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h8000_0010;
        bus.in_MemOp = 3'b010;
        bus.in_WrEn  = 1'b0;
        bus.in_RdEn  = 1'b1;
        step();
        bus.in_valid      = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", bus.in_ready, 32'd1);
        check("arst_req", bus.mem_req_valid, 32'd0);
        step();
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h1111_2222;
        step();
        bus.mem_rsp_valid = 1'b0;
        step();
        check("late_rsp_outv", bus.out_valid, 32'd0);
        check("late_rsp_ready", bus.in_ready, 32'd1);
        check("late_rsp_req", bus.mem_req_valid, 32'd0);

        // No response at all: timeout must end the wait with an error.
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h8000_0020;
        bus.in_MemOp = 3'b010;
        bus.in_WrEn  = 1'b0;
        bus.in_RdEn  = 1'b1;
        step();
        bus.in_valid      = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check("to_window", 32'((n >= 255) && (n <= 257)), 32'd1);
        check("to_err", bus.out_err, 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("to_drop", bus.out_valid, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
